// File: rtl/tmu_pkg.sv
// Shared constants and helpers for the TMU burst assembler.
package tmu_pkg;

  localparam int PIXELS_PER_BURST = 16;
  localparam int BURST_BITS       = 256;
  localparam int PIXEL_BITS       = 16;

  // Bit index of the most significant bit of pixel lane idx (big-endian lanes).
  function automatic logic [7:0] lane_msb(input logic [3:0] idx);
    return 8'd255 - {idx, 4'd0};
  endfunction

  // Width of a burst line address for a given FML byte-address width.
  function automatic int tag_w(input int fml_depth);
    return fml_depth - 5;
  endfunction

  // Select-mask bit for lane idx: lane 0 maps to bit 15.
  function automatic logic [15:0] lane_sel(input logic [3:0] idx);
    return 16'h8000 >> idx;
  endfunction

endpackage

// File: rtl/tmu_burst_outreg.sv
// Output holding register for completed bursts, with the stb/ack handshake.
// "free" means a new burst may be loaded this cycle without losing the current one.
module tmu_burst_outreg
  import tmu_pkg::*;
#(
  parameter int TAG_W = 21
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  load,
  input  logic [TAG_W-1:0]      load_addr,
  input  logic [15:0]           load_sel,
  input  logic [BURST_BITS-1:0] load_data,
  input  logic                  pipe_ack_i,
  output logic                  pipe_stb_o,
  output logic [TAG_W-1:0]      burst_addr,
  output logic [15:0]           burst_sel,
  output logic [BURST_BITS-1:0] burst_do,
  output logic                  free
);

  logic out_valid_r;

  assign pipe_stb_o = out_valid_r;
  assign free       = ~out_valid_r | pipe_ack_i;

  // Capture a transferred burst, or drop the current one once acknowledged.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      out_valid_r <= 1'b0;
      burst_addr  <= '0;
      burst_sel   <= 16'h0000;
      burst_do    <= '0;
    end else if (load) begin
      out_valid_r <= 1'b1;
      burst_addr  <= load_addr;
      burst_sel   <= load_sel;
      burst_do    <= load_data;
    end else if (pipe_ack_i) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: rtl/tmu_burst.sv
// Merges decayed RGB565 pixels into 16-pixel line bursts for the FML writer.
// Lines leave on a tag miss, when all 16 lanes are filled, or on an idle flush.
module tmu_burst
  import tmu_pkg::*;
#(
  parameter int fml_depth = 26
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       flush,
  output logic                       busy,
  input  logic                       pipe_stb_i,
  output logic                       pipe_ack_o,
  input  logic [15:0]                src_pixel_d,
  input  logic [fml_depth-2:0]       dst_addr,
  output logic                       pipe_stb_o,
  input  logic                       pipe_ack_i,
  output logic [tag_w(fml_depth)-1:0] burst_addr,
  output logic [15:0]                burst_sel,
  output logic [BURST_BITS-1:0]      burst_do
);

  localparam int TAG_W = tag_w(fml_depth);

  logic [TAG_W-1:0]      acc_tag_r, acc_tag_n;
  logic [15:0]           acc_sel_r, acc_sel_n;
  logic [BURST_BITS-1:0] acc_data_r, acc_data_n;
  logic                  acc_valid_r, acc_valid_n;

  logic [TAG_W-1:0] tag_s;
  logic [3:0]       idx_s;
  logic             miss_s;
  logic             full_s;
  logic             accept_s;
  logic             free_s;
  logic             out_valid_s;
  logic             xfer_s;

  assign idx_s    = dst_addr[3:0];
  assign tag_s    = dst_addr[fml_depth-2:4];
  assign miss_s   = acc_valid_r & (tag_s != acc_tag_r);
  assign full_s   = acc_valid_r & (acc_sel_r == 16'hFFFF);
  // A miss needs the output register; stall only while it is occupied.
  assign pipe_ack_o = ~(pipe_stb_i & miss_s & ~free_s);
  assign accept_s   = pipe_stb_i & pipe_ack_o;
  assign busy       = acc_valid_r | out_valid_s;

  // Next accumulator state and the transfer strobe toward the output register.
  always_comb begin
    xfer_s      = 1'b0;
    acc_valid_n = acc_valid_r;
    acc_tag_n   = acc_tag_r;
    acc_sel_n   = acc_sel_r;
    acc_data_n  = acc_data_r;
    if (accept_s && miss_s) begin
      // Old line leaves, incoming pixel starts a fresh line.
      xfer_s      = 1'b1;
      acc_valid_n = 1'b1;
      acc_tag_n   = tag_s;
      acc_sel_n   = lane_sel(idx_s);
      acc_data_n[lane_msb(idx_s) -: PIXEL_BITS] = src_pixel_d;
    end else if (full_s && free_s) begin
      // A complete line leaves; a same-cycle hit goes into a new line so it is not lost.
      xfer_s = 1'b1;
      if (accept_s) begin
        acc_valid_n = 1'b1;
        acc_tag_n   = tag_s;
        acc_sel_n   = lane_sel(idx_s);
        acc_data_n[lane_msb(idx_s) -: PIXEL_BITS] = src_pixel_d;
      end else begin
        acc_valid_n = 1'b0;
      end
    end else if (accept_s) begin
      if (acc_valid_r) begin
        acc_sel_n = acc_sel_r | lane_sel(idx_s);
      end else begin
        acc_valid_n = 1'b1;
        acc_tag_n   = tag_s;
        acc_sel_n   = lane_sel(idx_s);
      end
      acc_data_n[lane_msb(idx_s) -: PIXEL_BITS] = src_pixel_d;
    end else if (flush && !pipe_stb_i && acc_valid_r && free_s) begin
      xfer_s      = 1'b1;
      acc_valid_n = 1'b0;
    end else begin
      acc_valid_n = acc_valid_r;
    end
  end

  // Accumulator registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      acc_valid_r <= 1'b0;
      acc_tag_r   <= '0;
      acc_sel_r   <= 16'h0000;
      acc_data_r  <= '0;
    end else begin
      acc_valid_r <= acc_valid_n;
      acc_tag_r   <= acc_tag_n;
      acc_sel_r   <= acc_sel_n;
      acc_data_r  <= acc_data_n;
    end
  end

  tmu_burst_outreg #(
    .TAG_W (TAG_W)
  ) u_outreg (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .load       (xfer_s),
    .load_addr  (acc_tag_r),
    .load_sel   (acc_sel_r),
    .load_data  (acc_data_r),
    .pipe_ack_i (pipe_ack_i),
    .pipe_stb_o (out_valid_s),
    .burst_addr (burst_addr),
    .burst_sel  (burst_sel),
    .burst_do   (burst_do),
    .free       (free_s)
  );

  assign pipe_stb_o = out_valid_s;

endmodule

// File: tb/tb_tmu_burst.sv
// Directed bench for tmu_burst: hand-computed bursts for fill, miss, stall, overwrite, reset and flush.
module tb_tmu_burst;

  logic          sys_clk;
  logic          sys_rst_n;
  logic          flush;
  logic          busy;
  logic          pipe_stb_i;
  logic          pipe_ack_o;
  logic [15:0]   src_pixel_d;
  logic [24:0]   dst_addr;
  logic          pipe_stb_o;
  logic          pipe_ack_i;
  logic [20:0]   burst_addr;
  logic [15:0]   burst_sel;
  logic [255:0]  burst_do;

  int checks = 0;
  int errors = 0;

  logic [20:0]  q_addr[$];
  logic [15:0]  q_sel[$];
  logic [255:0] q_do[$];

  tmu_burst #(.fml_depth(26)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .flush       (flush),
    .busy        (busy),
    .pipe_stb_i  (pipe_stb_i),
    .pipe_ack_o  (pipe_ack_o),
    .src_pixel_d (src_pixel_d),
    .dst_addr    (dst_addr),
    .pipe_stb_o  (pipe_stb_o),
    .pipe_ack_i  (pipe_ack_i),
    .burst_addr  (burst_addr),
    .burst_sel   (burst_sel),
    .burst_do    (burst_do)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Record every burst that is handshaken at the coming rising edge.
  always @(negedge sys_clk) begin
    if (pipe_stb_o && pipe_ack_i && sys_rst_n) begin
      q_addr.push_back(burst_addr);
      q_sel.push_back(burst_sel);
      q_do.push_back(burst_do);
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [15:0] pix, input logic [24:0] addr);
    pipe_stb_i  = 1'b1;
    src_pixel_d = pix;
    dst_addr    = addr;
    tick();
    pipe_stb_i  = 1'b0;
  endtask

  // Wait (bounded) for a recorded burst, then check address, mask and one lane.
  task automatic expect_burst(input string tag, input logic [20:0] addr, input logic [15:0] sel,
                              input int lane, input logic [15:0] val, output logic [255:0] d);
    int n = 0;
    logic [15:0] got;
    while (q_addr.size() == 0 && n < 20) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    d = '0;
    if (q_addr.size() == 0) begin
      chk({tag, "_arrived"}, 256'(q_addr.size()), 256'd1);
    end else begin
      d = q_do.pop_front();
      chk({tag, "_addr"}, 256'(q_addr.pop_front()), 256'(addr));
      chk({tag, "_sel"}, 256'(q_sel.pop_front()), 256'(sel));
      got = d[255 - 16*lane -: 16];
      chk({tag, "_lane"}, 256'(got), 256'(val));
    end
  endtask

  initial begin
    logic [255:0] d;
    logic [255:0] exp_do;
    sys_rst_n   = 1'b0;
    flush       = 1'b0;
    pipe_stb_i  = 1'b0;
    pipe_ack_i  = 1'b0;
    src_pixel_d = 16'h0000;
    dst_addr    = 25'h0;
    repeat (3) tick();
    chk("rst_stb", 256'(pipe_stb_o), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_sel", 256'(burst_sel), 256'd0);
    chk("rst_addr", 256'(burst_addr), 256'd0);
    chk("rst_do", burst_do, 256'd0);
    sys_rst_n  = 1'b1;
    pipe_ack_i = 1'b1;
    tick();

    // Full line of 16 pixels.
    exp_do = '0;
    for (int i = 0; i < 16; i++) begin
      pipe_stb_i  = 1'b1;
      src_pixel_d = 16'h1000 + 16'(i);
      dst_addr    = 25'h100 + 25'(i);
      exp_do[255 - 16*i -: 16] = 16'h1000 + 16'(i);
      #1;
      chk("fill_ack", 256'(pipe_ack_o), 256'd1);
      tick();
    end
    pipe_stb_i = 1'b0;
    #1;
    chk("full_n1_stb", 256'(pipe_stb_o), 256'd0);
    tick();
    chk("full_n2_stb", 256'(pipe_stb_o), 256'd1);
    expect_burst("full", 21'h10, 16'hFFFF, 0, 16'h1000, d);
    chk("full_do", d, exp_do);
    chk("full_last", 256'(d[15:0]), 256'h100F);
    repeat (3) tick();
    chk("full_single", 256'(q_addr.size()), 256'd0);
    chk("full_idle", 256'(busy), 256'd0);

    // Miss emission, then flush of the remainder.
    send(16'hAAAA, 25'h203);
    send(16'hBBBB, 25'h305);
    chk("miss_n1_stb", 256'(pipe_stb_o), 256'd1);
    expect_burst("miss", 21'h20, 16'h1000, 3, 16'hAAAA, d);
    flush = 1'b1;
    expect_burst("flush", 21'h30, 16'h0400, 5, 16'hBBBB, d);
    flush = 1'b0;
    repeat (3) tick();
    chk("flush_idle", 256'(busy), 256'd0);

    // Stall on miss while the output register is held.
    pipe_ack_i = 1'b0;
    send(16'h1234, 25'h500);
    send(16'h5678, 25'h610);
    pipe_stb_i  = 1'b1;
    src_pixel_d = 16'h9ABC;
    dst_addr    = 25'h720;
    #1;
    chk("stall_ack0", 256'(pipe_ack_o), 256'd0);
    tick();
    chk("stall_ack1", 256'(pipe_ack_o), 256'd0);
    chk("stall_stb", 256'(pipe_stb_o), 256'd1);
    chk("stall_addr", 256'(burst_addr), 256'h50);
    pipe_ack_i = 1'b1;
    #1;
    chk("release_ack", 256'(pipe_ack_o), 256'd1);
    tick();
    pipe_stb_i = 1'b0;
    expect_burst("stall_a", 21'h50, 16'h8000, 0, 16'h1234, d);
    expect_burst("stall_b", 21'h61, 16'h8000, 0, 16'h5678, d);
    flush = 1'b1;
    expect_burst("stall_c", 21'h72, 16'h8000, 0, 16'h9ABC, d);
    flush = 1'b0;
    repeat (3) tick();
    chk("stall_nodup", 256'(q_addr.size()), 256'd0);

    // Same lane written twice: newer pixel wins.
    send(16'h1111, 25'h407);
    send(16'h2222, 25'h407);
    flush = 1'b1;
    expect_burst("ovw", 21'h40, 16'h0100, 7, 16'h2222, d);
    flush = 1'b0;
    repeat (3) tick();
    chk("ovw_single", 256'(q_addr.size()), 256'd0);

    // Reset with a held burst and a half-full accumulator.
    pipe_ack_i = 1'b0;
    send(16'h3000, 25'h800);
    send(16'h3001, 25'h801);
    for (int i = 0; i < 8; i++) send(16'h4000 + 16'(i), 25'h900 + 25'(i));
    chk("prerst_busy", 256'(busy), 256'd1);
    chk("prerst_stb", 256'(pipe_stb_o), 256'd1);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    chk("mid_rst_stb", 256'(pipe_stb_o), 256'd0);
    chk("mid_rst_busy", 256'(busy), 256'd0);
    chk("mid_rst_sel", 256'(burst_sel), 256'd0);
    pipe_ack_i = 1'b1;
    flush      = 1'b1;
    repeat (4) tick();
    flush = 1'b0;
    chk("rst_flush_none", 256'(q_addr.size()), 256'd0);
    chk("rst_flush_stb", 256'(pipe_stb_o), 256'd0);

    // Flush held while a hit stream is still arriving.
    flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pipe_stb_i  = 1'b1;
      src_pixel_d = 16'h5000 + 16'(i);
      dst_addr    = 25'hA00 + 25'(i);
      tick();
      chk("fstream_stb", 256'(pipe_stb_o), 256'd0);
    end
    pipe_stb_i = 1'b0;
    tick();
    chk("fstream_emit", 256'(pipe_stb_o), 256'd1);
    expect_burst("fstream", 21'hA0, 16'hF000, 3, 16'h5003, d);
    chk("fstream_lane0", 256'(d[255:240]), 256'h5000);
    flush = 1'b0;
    repeat (3) tick();
    chk("fstream_single", 256'(q_addr.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
